// File: rtl/snn_cfg_writer_pkg.sv
// Shared types for the SNN config writer: Q8.8 fixed point, FSM states.
// Weight saturation defaults live here so layer and writer agree.
package snn_cfg_writer_pkg;

  localparam int FX_W    = 16;
  localparam int FX_FRAC = 8;

  typedef logic signed [FX_W-1:0] fx_t;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } cfg_state_e;

  // Q8.8 encodings of +0.75 and -0.75
  localparam fx_t FX_W_MAX = fx_t'(192);
  localparam fx_t FX_W_MIN = fx_t'(-192);

endpackage

// File: rtl/snn_cfg_writer_if.sv
// Host-side command and data-beat handshakes for snn_cfg_writer.
// master = host/bus bridge, slave = writer.
interface snn_cfg_writer_if #(
  parameter int CFG_ADDR_W = 2,
  parameter int LEN_W      = 8
) ();
  import snn_cfg_writer_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_sel_delay;
  logic [CFG_ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]      cmd_len;
  logic                  dat_valid;
  logic                  dat_ready;
  fx_t                   dat_word;

  modport master (
    output cmd_valid, cmd_sel_delay, cmd_addr, cmd_len,
    output dat_valid, dat_word,
    input  cmd_ready, dat_ready
  );

  modport slave (
    input  cmd_valid, cmd_sel_delay, cmd_addr, cmd_len,
    input  dat_valid, dat_word,
    output cmd_ready, dat_ready
  );

endinterface

// File: rtl/snn_cfg_writer_sat.sv
// Combinational weight/delay saturator with clamp flag.
// Reusable for STDP weight clamp paths.
module snn_cfg_sat
  import snn_cfg_writer_pkg::*;
#(
  parameter fx_t W_MAX     = FX_W_MAX,
  parameter fx_t W_MIN     = FX_W_MIN,
  parameter int  MAX_DELAY = 4
) (
  input  logic       sel_delay,
  input  fx_t        word,
  output fx_t        wdata,
  output logic [7:0] delay,
  output logic       clamp
);

  always_comb begin
    wdata = word;
    delay = word[7:0];
    clamp = 1'b0;
    if (sel_delay) begin
      if (word[7:0] > 8'(MAX_DELAY)) begin
        delay = 8'(MAX_DELAY);
        clamp = 1'b1;
      end
    end else if (word > W_MAX) begin
      wdata = W_MAX;
      clamp = 1'b1;
    end else if (word < W_MIN) begin
      wdata = W_MIN;
      clamp = 1'b1;
    end
  end

endmodule

// File: rtl/snn_cfg_writer.sv
// Burst config master for an SNN layer weight/delay port.
// Define SNN_CFG_SPIKE_GATE_EN to block input spikes while busy.
module snn_cfg_writer
  import snn_cfg_writer_pkg::*;
#(
  parameter int  NUM_INPUTS  = 2,
  parameter int  NUM_NEURONS = 2,
  parameter int  MAX_DELAY   = 4,
  parameter int  CFG_ADDR_W  = (NUM_NEURONS * NUM_INPUTS > 1) ?
                               $clog2(NUM_NEURONS * NUM_INPUTS) : 1,
  parameter int  LEN_W       = 8,
  parameter fx_t W_MAX       = FX_W_MAX,
  parameter fx_t W_MIN       = FX_W_MIN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  snn_cfg_writer_if.slave       host,
  input  logic                  abort,
  input  logic                  err_clr,
  input  logic [NUM_INPUTS-1:0] pre_spikes_in,
  output logic [NUM_INPUTS-1:0] pre_spikes_out,
  output logic                  cfg_we,
  output logic                  cfg_sel_delay,
  output logic [CFG_ADDR_W-1:0] cfg_addr,
  output fx_t                   cfg_wdata,
  output logic [7:0]            cfg_delay,
  output logic                  busy,
  output logic                  done,
  output logic                  err_oob,
  output logic                  err_clamp
);

  localparam int NSYN = NUM_NEURONS * NUM_INPUTS;
  // Wide enough that a burst running off the end never wraps
  localparam int AW   = CFG_ADDR_W + LEN_W + 1;

  cfg_state_e            state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic                  sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  csel_q, csel_d;
  logic [CFG_ADDR_W-1:0] caddr_q, caddr_d;
  fx_t                   wdata_q, wdata_d;
  logic [7:0]            delay_q, delay_d;
  logic                  done_q, done_d;
  logic                  oob_q, oob_d;
  logic                  clamp_q, clamp_d;

  logic       beat;
  logic       in_range;
  logic       oob_set;
  logic       clamp_set;
  fx_t        sat_w;
  logic [7:0] sat_d;
  logic       sat_clamp;

  snn_cfg_sat #(
    .W_MAX     (W_MAX),
    .W_MIN     (W_MIN),
    .MAX_DELAY (MAX_DELAY)
  ) u_sat (
    .sel_delay (sel_q),
    .word      (host.dat_word),
    .wdata     (sat_w),
    .delay     (sat_d),
    .clamp     (sat_clamp)
  );

  assign host.cmd_ready = (state_q == S_IDLE);
  assign host.dat_ready = (state_q == S_BURST);
  assign beat           = host.dat_valid & host.dat_ready;
  assign in_range       = addr_q < AW'(NSYN);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    sel_d     = sel_q;
    we_d      = 1'b0;
    csel_d    = csel_q;
    caddr_d   = caddr_q;
    wdata_d   = wdata_q;
    delay_d   = delay_q;
    done_d    = 1'b0;
    oob_set   = 1'b0;
    clamp_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (host.cmd_valid) begin
          sel_d   = host.cmd_sel_delay;
          addr_d  = AW'(host.cmd_addr);
          rem_d   = host.cmd_len;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (beat) begin
          if (in_range) begin
            we_d      = 1'b1;
            csel_d    = sel_q;
            caddr_d   = addr_q[CFG_ADDR_W-1:0];
            clamp_set = sat_clamp;
            if (sel_q) delay_d = sat_d;
            else       wdata_d = sat_w;
          end else begin
            oob_set = 1'b1;
          end
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == '0) begin
            state_d = S_IDLE;
            done_d  = ~abort;
          end
        end
        if (abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    oob_d   = err_clr ? 1'b0 : (oob_q | oob_set);
    clamp_d = err_clr ? 1'b0 : (clamp_q | clamp_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      csel_q  <= 1'b0;
      caddr_q <= '0;
      wdata_q <= '0;
      delay_q <= '0;
      done_q  <= 1'b0;
      oob_q   <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      csel_q  <= csel_d;
      caddr_q <= caddr_d;
      wdata_q <= wdata_d;
      delay_q <= delay_d;
      done_q  <= done_d;
      oob_q   <= oob_d;
      clamp_q <= clamp_d;
    end
  end

  assign cfg_we        = we_q;
  assign cfg_sel_delay = csel_q;
  assign cfg_addr      = caddr_q;
  assign cfg_wdata     = wdata_q;
  assign cfg_delay     = delay_q;
  assign busy          = (state_q == S_BURST);
  assign done          = done_q;
  assign err_oob       = oob_q;
  assign err_clamp     = clamp_q;

`ifdef SNN_CFG_SPIKE_GATE_EN
  assign pre_spikes_out = busy ? '0 : pre_spikes_in;
`else
  assign pre_spikes_out = pre_spikes_in;
`endif

endmodule
